// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, divisor floor and parity modes shared by the UART transmitter.
package uart_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam int MIN_DIV = 2;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO; dout shows the head entry whenever not empty.
module uart_sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 16,
    parameter int P_LVL_W = $clog2(P_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [P_WIDTH-1:0] din,
    output logic [P_WIDTH-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [P_LVL_W-1:0] level
);
    localparam int A_W = $clog2(P_DEPTH);
    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [A_W-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = level == P_LVL_W'(P_DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + A_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + A_W'(1);
            level <= level + P_LVL_W'(do_push) - P_LVL_W'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-backed UART transmitter with runtime divisor and stop-bit count.
// Define UART_TX_PARITY_EN to add the parity ports and the PARITY state.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int P_DATA_W     = 8,
    parameter int P_FIFO_DEPTH = 16,
    parameter int P_DIV_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_DATA_W-1:0]                 i_data,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [P_DIV_W-1:0]                  i_baud_div,
    input  logic                                i_stop2,
`ifdef UART_TX_PARITY_EN
    input  logic                                i_parity_en,
    input  logic                                i_parity_odd,
`endif
    output logic                                o_tx,
    output logic                                o_busy,
    output logic [$clog2(P_FIFO_DEPTH+1)-1:0]   o_level
);
    localparam int BI_W = $clog2(P_DATA_W);
    logic [P_DATA_W-1:0] head, sh;
    logic full, empty, pop, bit_end, last_stop, stop2_q, stop_idx;
    logic [2:0] state;
    logic [P_DIV_W-1:0] cnt, div_q, div_c;
    logic [BI_W-1:0] bit_idx;
`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_q;
`endif
    assign o_ready   = !full;
    assign o_busy    = state != ST_IDLE;
    assign div_c     = i_baud_div < P_DIV_W'(MIN_DIV) ? P_DIV_W'(MIN_DIV) : i_baud_div;
    assign bit_end   = cnt == div_q - P_DIV_W'(1);
    assign last_stop = state == ST_STOP && bit_end && (!stop2_q || stop_idx);
    // Popping at the end of the last stop bit chains frames with no idle clock.
    assign pop       = !empty && (state == ST_IDLE || last_stop);

    uart_sync_fifo #(.P_WIDTH(P_DATA_W), .P_DEPTH(P_FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(i_valid), .pop(pop), .din(i_data),
        .dout(head), .full(full), .empty(empty), .level(o_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            o_tx     <= 1'b1;
            cnt      <= '0;
            div_q    <= P_DIV_W'(MIN_DIV);
            stop2_q  <= 1'b0;
            stop_idx <= 1'b0;
            bit_idx  <= '0;
            sh       <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else if (pop) begin
            state    <= ST_START;
            o_tx     <= 1'b0;
            cnt      <= '0;
            div_q    <= div_c;
            stop2_q  <= i_stop2;
            stop_idx <= 1'b0;
            bit_idx  <= '0;
            sh       <= head;
`ifdef UART_TX_PARITY_EN
            par_en_q <= i_parity_en;
            par_q    <= (^head) ^ (i_parity_odd == PAR_ODD);
`endif
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                cnt <= cnt + P_DIV_W'(1);
            end else begin
                cnt <= '0;
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        o_tx  <= sh[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == BI_W'(P_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                            o_tx  <= par_en_q ? par_q : 1'b1;
`else
                            state <= ST_STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + BI_W'(1);
                            sh      <= sh >> 1;
                            o_tx    <= sh[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        state <= ST_STOP;
                        o_tx  <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        if (stop2_q && !stop_idx) stop_idx <= 1'b1;
                        else state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Next-generation UART transmitter with a byte-stream valid/ready input backed by an internal FIFO.
- Runtime-programmable baud divisor, stop-bit count and optional parity; data width set by parameter.
- Frames go out back-to-back with no idle gap while the FIFO holds data.
- Sits between a producer (CPU/DMA/test pattern logic) and the serial pin.

Parameters:
- P_DATA_W, 8, data bits per frame, legal range 5..9.
- P_FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- P_DIV_W, 16, width of the runtime baud divisor.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_data  in  P_DATA_W  byte to enqueue
- i_valid  in  1  i_data valid
- o_ready  out  1  FIFO can accept; high when not full
- i_baud_div  in  P_DIV_W  clocks per bit; values < 2 are treated as 2
- i_stop2  in  1  0 = one stop bit, 1 = two stop bits
- o_tx  out  1  serial line, idle high, registered
- o_busy  out  1  high when a frame is in progress (state != IDLE)
- o_level  out  $clog2(P_FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: o_tx=1, o_busy=0, o_ready=1, o_level=0. FIFO is flushed. State = IDLE.
- Reset mid-frame: o_tx=1 from the next edge. The partial frame is abandoned and all queued data is discarded.
- Push rule: a push occurs when i_valid && o_ready. o_ready = !full and ignores any pop in the same cycle.
- Pop rule: pop only when not empty. A simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
- IDLE: when the FIFO is not empty:
  - pop the head into the shift register;
  - latch i_baud_div (clamped), i_stop2 and parity controls for the whole frame;
  - go to START.
  - Mid-frame control changes have no effect.
- Latency: a push accepted at edge N gives o_level=1 after N. The pop occurs at edge N+1 and o_tx=0 from edge N+1.
- Bit timing:
  - A counter clears on each state/bit change and counts 0..div-1; the bit advances when count == div-1.
  - Each bit lasts exactly div clocks. There is no free-running prescaler; the counter restarts at each frame.
- START: o_tx=0 for one bit, then DATA.
- DATA: transmits P_DATA_W bits LSB first. After the last bit, goes to PARITY if enabled, otherwise STOP.
- STOP: o_tx=1 for 1 or 2 bits. At the end:
  - FIFO not empty: pop and go directly to START (zero idle clocks between frames).
  - FIFO empty: go to IDLE.
- Frame length: (1 + P_DATA_W + parity + stop) * div clocks.
- o_level and o_ready update the cycle after a push or pop.
- Pushes are accepted at any time, including mid-frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Ports i_parity_en (1 bit) and i_parity_odd (1 bit) exist and are latched at frame start.
  - When enabled, the PARITY state sends one bit after the data bits: the XOR of the data bits (even), or its inverse (odd).
- Undefined:
  - Those ports and the PARITY state are absent; frames never carry parity.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding (3-bit localparams ST_IDLE..ST_STOP);
  - the minimum divisor constant (2);
  - the parity-mode encoding.
- Sub-module uart_sync_fifo: a synchronous FIFO parametrised by width and depth. Ports: push, pop, din, dout, full, empty, level; first-word data valid while not empty.
- uart_tx_stream instantiates the FIFO and contains the FSM, bit counter and shifter.

Test Plan:
- Single frame: push 0xA5, div=4, 8N1 -> o_tx low at the cycle after push + 1, then bits 1,0,1,0,0,1,0,1, then high. Each bit is 4 clocks; 40 clocks total; o_busy falls after the stop bit.
- Back-to-back: push 0x00, 0xFF, 0x55, div=3, i_stop2=1 -> three 11-bit frames (33 clocks each) with no idle clocks between them; o_level reaches 0 at the third pop.
- FIFO full: div=100, 18 consecutive pushes -> 17 accepted (one popped into the shifter), o_level=16, o_ready=0. The 18th is refused until the next pop. Output byte order matches push order.
- Divisor clamp and latch: div=0 -> bits are 2 clocks. Change div 4->8 mid-frame -> the current frame stays at 4; the next frame uses 8.
- Reset mid-frame: assert rst during DATA bit 3 -> o_tx=1 next cycle, o_level=0, o_ready=1. No residual frame after rst deasserts.
- Parity (UART_TX_PARITY_EN): 0xA5 with even parity -> parity bit 0; odd -> 1. 0x07 even -> 1. Frame length is 11 bits.
